decode_ctrl: RTL

//  Sequences one Frodo key-decode pass: reads the 8x8 matrix of 16-bit coefficients
//  (4 per 64-bit word, 16 words) from the coefficient RAM and streams it through the

---
 rtl/decode_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl.sv
// decode_ctrl: sequences one key-decode pass over an 8x8 matrix of 16-bit coefficients.
// It reads NWORDS 64-bit words from the coefficient RAM, feeds each one to an external
// combinational Decode block, and packs the low B bits of every lane into 64-bit words.
// B is 4, 3 or 2 for levels 01, 10 and 11.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start, level               start pulse; level is sampled when start is accepted
//   busy, done, err            pass in progress, pass-complete pulse, bad-level pulse
//   mem_rd_en/addr/data        RAM read port; data returns one cycle after the strobe
//   dec_en/level/in/out        Decode datapath; dec_out is valid in the same cycle as dec_in
//   ss_valid/ready/data        shared-secret output stream (valid/ready handshake)
module decode_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned NWORDS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        level,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [63:0]       mem_rd_data,
    output logic              dec_en,
    output logic [1:0]        dec_level,
    output logic [63:0]       dec_in,
    input  logic [63:0]       dec_out,
    output logic              ss_valid,
    input  logic              ss_ready,
    output logic [63:0]       ss_data
);

    localparam int unsigned CNT_W = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] word_cnt_q;  // reads issued this pass
    logic             cap_v_q;     // mem_rd_data is valid this cycle
    logic             dec_v_q;     // dec_in/dec_out is valid this cycle
    logic [127:0]     acc_q;
    logic [7:0]       acc_cnt_q;

    // Only the low B bits of each lane are meaningful; the rest is ignored on purpose.
    logic unused_dec;
    assign unused_dec = ^dec_out;

    // Gather the 4 lane chunks into one contiguous 4B-bit group, lane 0 at the bottom.
    logic [15:0] group;
    logic [7:0]  group_w;
    always_comb begin
        group   = '0;
        group_w = '0;
        unique case (dec_level)
            2'b01: begin
                group   = {dec_out[48 +: 4], dec_out[32 +: 4], dec_out[16 +: 4], dec_out[0 +: 4]};
                group_w = 8'd16;
            end
            2'b10: begin
                group   = {4'b0, dec_out[48 +: 3], dec_out[32 +: 3], dec_out[16 +: 3],
                           dec_out[0 +: 3]};
                group_w = 8'd12;
            end
            2'b11: begin
                group   = {8'b0, dec_out[48 +: 2], dec_out[32 +: 2], dec_out[16 +: 2],
                           dec_out[0 +: 2]};
                group_w = 8'd8;
            end
            default: ;
        endcase
    end

    // Pack and emit may happen in the same cycle. Emit takes acc_q[63:0], which the
    // incoming group cannot touch because it lands at or above bit acc_cnt_q >= 64.
    logic         emit;
    logic [127:0] acc_packed;
    logic [127:0] acc_next;
    logic [7:0]   cnt_packed;
    logic [7:0]   cnt_next;
    always_comb begin
        acc_packed = acc_q;
        cnt_packed = acc_cnt_q;
        if (dec_v_q) begin
            acc_packed = acc_q | ({112'b0, group} << acc_cnt_q);
            cnt_packed = acc_cnt_q + group_w;
        end
        emit     = (acc_cnt_q >= 8'd64) && (!ss_valid || ss_ready);
        acc_next = acc_packed;
        cnt_next = cnt_packed;
        if (emit) begin
            acc_next = acc_packed >> 64;
            cnt_next = cnt_packed - 8'd64;
        end
    end

    // Budget: reserve 16 bits for each read that is still in the pipe after this edge,
    // so the accumulator cannot overflow while the consumer stalls.
    logic [8:0] pending_bits;
    logic       issue;
    always_comb begin
        pending_bits = {1'b0, cnt_next} + (mem_rd_en ? 9'd16 : 9'd0) + (cap_v_q ? 9'd16 : 9'd0);
        issue        = (state_q == StRun) && (word_cnt_q != CNT_W'(NWORDS))
                       && (pending_bits < 9'd96);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            cap_v_q     <= 1'b0;
            dec_v_q     <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            dec_en      <= 1'b0;
            dec_level   <= '0;
            dec_in      <= '0;
            ss_valid    <= 1'b0;
            ss_data     <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= issue;
            cap_v_q   <= mem_rd_en;
            dec_v_q   <= cap_v_q;
            acc_q     <= acc_next;
            acc_cnt_q <= cnt_next;
            if (cap_v_q) begin
                dec_in <= mem_rd_data;
            end
            if (emit) begin
                ss_data  <= acc_q[63:0];
                ss_valid <= 1'b1;
            end else if (ss_ready) begin
                ss_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (level != 2'b00) begin
                            state_q    <= StRun;
                            busy       <= 1'b1;
                            dec_en     <= 1'b1;
                            dec_level  <= level;
                            word_cnt_q <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (word_cnt_q == CNT_W'(NWORDS)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!mem_rd_en && !cap_v_q && !dec_v_q && acc_cnt_q == 8'd0 && !ss_valid) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    dec_en  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            if (issue) begin
                mem_rd_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
                word_cnt_q  <= word_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
